// File: rtl/cs_udp_tx_frame_if.sv
// Byte-stream handshake from the UDP frame builder to the MAC TX path.
// A byte transfers on every clock edge where tx_valid and tx_ready are both high.
interface cs_udp_tx_frame_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/cs_udp_tx_frame.sv
// UDP payload frame builder: sync/descriptor header, N FIFO-drained device blocks,
// then an 8-bit additive checksum, streamed byte-wise over valid/ready.
module cs_udp_tx_frame #(
  parameter int unsigned BLOCK_LEN = 32,
  parameter logic [7:0]  SYNC0     = 8'h55,
  parameter logic [7:0]  SYNC1     = 8'hAA
) (
  input  logic              clk,
  input  logic              rst_dev,
  input  logic              fs_udp_tx,
  output logic              fd_udp_tx,
  input  logic [7:0]        fifo2mac_num,
  input  logic [7:0]        dev_info,
  input  logic [7:0]        dev_kind,
  input  logic [7:0]        dev_smpr,
  output logic              fifo_rd_en,
  input  logic [7:0]        fifo_rd_data,
  input  logic              fifo_empty,
  cs_udp_tx_frame_if.master tx
);

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_RD, S_LAT, S_PAY, S_CSUM, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  pay_byte_q, pay_byte_d;
  logic [7:0]  info_q, info_d;
  logic [7:0]  kind_q, kind_d;
  logic [7:0]  smpr_q, smpr_d;
  logic [7:0]  num_q, num_d;

  logic [7:0]  hdr_byte;
  logic [15:0] pay_total;
  logic        accept;

  // Worst case 255*255 fits in 16 bits, so the payload counter never wraps.
  assign pay_total = 16'(num_q) * 16'(BLOCK_LEN);
  assign accept    = tx.tx_valid & tx.tx_ready;

  always_comb begin
    unique case (hdr_idx_q)
      3'd0:    hdr_byte = SYNC0;
      3'd1:    hdr_byte = SYNC1;
      3'd2:    hdr_byte = info_q;
      3'd3:    hdr_byte = kind_q;
      3'd4:    hdr_byte = smpr_q;
      default: hdr_byte = num_q;
    endcase
  end

  // NOTE: every register uses non-blocking assignment so all flops sample the
  // pre-edge values of their peers regardless of process ordering.
  always_ff @(posedge clk or posedge rst_dev) begin
    if (rst_dev) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= '0;
      pay_cnt_q  <= '0;
      csum_q     <= '0;
      pay_byte_q <= '0;
      info_q     <= '0;
      kind_q     <= '0;
      smpr_q     <= '0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      pay_cnt_q  <= pay_cnt_d;
      csum_q     <= csum_d;
      pay_byte_q <= pay_byte_d;
      info_q     <= info_d;
      kind_q     <= kind_d;
      smpr_q     <= smpr_d;
      num_q      <= num_d;
    end
  end

  // NOTE: every _d signal defaults to its _q value first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    pay_cnt_d  = pay_cnt_q;
    csum_d     = csum_q;
    pay_byte_d = pay_byte_q;
    info_d     = info_q;
    kind_d     = kind_q;
    smpr_d     = smpr_q;
    num_d      = num_q;

    unique case (state_q)
      S_IDLE: begin
        if (fs_udp_tx) begin
          info_d    = dev_info;
          kind_d    = dev_kind;
          smpr_d    = dev_smpr;
          num_d     = fifo2mac_num;
          hdr_idx_d = '0;
          pay_cnt_d = '0;
          csum_d    = '0;
          state_d   = S_HEAD;
        end
      end
      S_HEAD: begin
        if (accept) begin
          // The two sync bytes stay out of the checksum.
          if (hdr_idx_q >= 3'd2) csum_d = csum_q + hdr_byte;
          if (hdr_idx_q == 3'd5) state_d = (num_q != 8'd0) ? S_RD : S_CSUM;
          else                   hdr_idx_d = hdr_idx_q + 3'd1;
        end
      end
      S_RD: begin
        if (!fifo_empty) state_d = S_LAT;
      end
      S_LAT: begin
        pay_byte_d = fifo_rd_data;
        state_d    = S_PAY;
      end
      S_PAY: begin
        if (accept) begin
          csum_d    = csum_q + pay_byte_q;
          pay_cnt_d = pay_cnt_q + 16'd1;
          state_d   = (pay_cnt_d == pay_total) ? S_CSUM : S_RD;
        end
      end
      S_CSUM: begin
        if (accept) state_d = S_DONE;
      end
      S_DONE: begin
        if (!fs_udp_tx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the registered state only, so they stay stable under backpressure.
  always_comb begin
    tx.tx_data  = 8'h00;
    tx.tx_valid = 1'b0;
    tx.tx_last  = 1'b0;
    fifo_rd_en  = 1'b0;
    fd_udp_tx   = 1'b0;

    unique case (state_q)
      S_HEAD: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = hdr_byte;
      end
      S_RD:   fifo_rd_en = !fifo_empty;
      S_PAY: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = pay_byte_q;
      end
      S_CSUM: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = csum_q;
        tx.tx_last  = 1'b1;
      end
      S_DONE: fd_udp_tx = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cs_udp_tx_frame.sv
// Directed bench for cs_udp_tx_frame: a BLOCK_LEN=4 instance for the frame
// scenarios and a BLOCK_LEN=32 instance for the full N=255 frame.
module tb_cs_udp_tx_frame;

  logic clk;
  logic rst_dev;
  logic fs_a, fd_a, rd_en_a, empty_a;
  logic [7:0] rd_data_a;
  logic fs_b, fd_b, rd_en_b, empty_b;
  logic [7:0] rd_data_b;
  logic [7:0] num, info, kind, smpr;

  int total = 0;
  int bad   = 0;

  cs_udp_tx_frame_if txa ();
  cs_udp_tx_frame_if txb ();

  cs_udp_tx_frame #(.BLOCK_LEN(4)) u_dut (
    .clk(clk), .rst_dev(rst_dev), .fs_udp_tx(fs_a), .fd_udp_tx(fd_a),
    .fifo2mac_num(num), .dev_info(info), .dev_kind(kind), .dev_smpr(smpr),
    .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data_a), .fifo_empty(empty_a),
    .tx(txa)
  );

  cs_udp_tx_frame #(.BLOCK_LEN(32)) u_big (
    .clk(clk), .rst_dev(rst_dev), .fs_udp_tx(fs_b), .fd_udp_tx(fd_b),
    .fifo2mac_num(num), .dev_info(info), .dev_kind(kind), .dev_smpr(smpr),
    .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data_b), .fifo_empty(empty_b),
    .tx(txb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model for the small instance: bytes loaded by the tests, read data one cycle after rd_en.
  logic [7:0] mem_a [0:15];
  int  wr_a = 0;
  int  rd_ptr_a = 0;
  bit  hold_empty = 1'b0;
  assign empty_a = hold_empty || (rd_ptr_a >= wr_a);
  always @(posedge clk) begin
    if (rd_en_a) begin
      rd_data_a <= mem_a[rd_ptr_a % 16];
      rd_ptr_a  <= rd_ptr_a + 1;
    end
  end

  // FIFO model for the big instance: never empty, byte i = i*7+3.
  int rd_ptr_b = 0;
  assign empty_b = 1'b0;
  always @(posedge clk) begin
    if (rd_en_b) begin
      rd_data_b <= 8'(rd_ptr_b * 7 + 3);
      rd_ptr_b  <= rd_ptr_b + 1;
    end
  end

  // Monitors sample on the falling edge, half a cycle away from the active edge.
  logic [7:0] acc_a [$];
  bit         last_a [$];
  int cyc = 0, rd_cnt_a = 0, rd_empty_a = 0, stab_a = 0, stall_viol = 0;
  int last_acc_cyc = 0, fd_rise_cyc = 0;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0, pfd = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_a) rd_cnt_a <= rd_cnt_a + 1;
    if (rd_en_a && empty_a) rd_empty_a <= rd_empty_a + 1;
    if (txa.tx_valid && txa.tx_ready) begin
      acc_a.push_back(txa.tx_data);
      last_a.push_back(txa.tx_last);
      if (txa.tx_last) last_acc_cyc <= cyc;
    end
    if (pv && !pr && (!txa.tx_valid || txa.tx_data !== pd || txa.tx_last !== pl))
      stab_a <= stab_a + 1;
    if (hold_empty && (txa.tx_valid || rd_en_a)) stall_viol <= stall_viol + 1;
    if (fd_a && !pfd) fd_rise_cyc <= cyc;
    pv  <= txa.tx_valid;
    pr  <= txa.tx_ready;
    pd  <= txa.tx_data;
    pl  <= txa.tx_last;
    pfd <= fd_a;
  end

  int nb = 0, lastpos_b = 0, lastcnt_b = 0, rd_cnt_b = 0;
  logic [7:0] lastbyte_b = 8'h00;
  always @(negedge clk) begin
    if (rd_en_b) rd_cnt_b <= rd_cnt_b + 1;
    if (txb.tx_valid && txb.tx_ready) begin
      nb <= nb + 1;
      if (txb.tx_last) begin
        lastpos_b  <= nb + 1;
        lastbyte_b <= txb.tx_data;
        lastcnt_b  <= lastcnt_b + 1;
      end
    end
  end

  task automatic load_fifo(input logic [7:0] b0, b1, b2, b3);
    mem_a[wr_a % 16]       = b0;
    mem_a[(wr_a + 1) % 16] = b1;
    mem_a[(wr_a + 2) % 16] = b2;
    mem_a[(wr_a + 3) % 16] = b3;
    wr_a = wr_a + 4;
  endtask

  // Raises fs and runs the small instance until fd, with optional backpressure,
  // a 10-cycle FIFO-empty stall after stall_at accepted bytes, and input scrambling.
  task automatic run_frame(input int ready_mode, input int stall_at, input bit scramble,
                           output bit timed_out);
    int base, stall_left;
    bit stalled;
    logic [7:0] s_info, s_kind, s_smpr, s_num;
    base = acc_a.size();
    stalled = 1'b0;
    stall_left = 0;
    timed_out = 1'b1;
    {s_info, s_kind, s_smpr, s_num} = {info, kind, smpr, num};
    fs_a = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (scramble && c == 0) {info, kind, smpr, num} = {8'hEE, 8'h77, 8'h66, 8'h09};
      if (!stalled && stall_at >= 0 && acc_a.size() - base == stall_at) begin
        stalled = 1'b1;
        stall_left = 10;
        hold_empty = 1'b1;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) hold_empty = 1'b0;
      end
      txa.tx_ready = (ready_mode == 0) ? 1'b1 : 1'((c % 3) == 0);
      if (fd_a) begin
        timed_out = 1'b0;
        break;
      end
    end
    hold_empty = 1'b0;
    {info, kind, smpr, num} = {s_info, s_kind, s_smpr, s_num};
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_dev = 1'b1;
    fs_a = 1'b0; fs_b = 1'b0;
    txa.tx_ready = 1'b0; txb.tx_ready = 1'b1;
    info = 8'h12; kind = 8'h03; smpr = 8'h04; num = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({fd_a, rd_en_a, txa.tx_valid, txa.tx_last, txa.tx_data} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs_a got=%h want=000", {fd_a, rd_en_a, txa.tx_valid, txa.tx_last, txa.tx_data});
    end
    total++;
    if ({fd_b, rd_en_b, txb.tx_valid, txb.tx_last, txb.tx_data} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs_b got=%h want=000", {fd_b, rd_en_b, txb.tx_valid, txb.tx_last, txb.tx_data});
    end
    rst_dev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (txa.tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_without_fs got=%b want=0", txa.tx_valid);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp [$];
    int base, rd0;
    bit to;
    logic [8:0] got;
    exp = '{8'h55, 8'hAA, 8'h12, 8'h03, 8'h04, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h24};
    load_fifo(8'h01, 8'h02, 8'h03, 8'h04);
    num = 8'h01;
    base = acc_a.size();
    rd0 = rd_cnt_a;
    run_frame(0, -1, 1'b1, to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout got=no_fd want=fd"); end
    total++;
    if (acc_a.size() - base != exp.size()) begin
      bad++;
      $display("FAIL basic_len got=%0d want=%0d", acc_a.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < acc_a.size()) ? {last_a[base + i], acc_a[base + i]} : 'x;
      total++;
      if (got !== {1'(i == exp.size() - 1), exp[i]}) begin
        bad++;
        $display("FAIL basic_byte%0d got=%h want=%h", i, got, {1'(i == exp.size() - 1), exp[i]});
      end
    end
    total++;
    if (rd_cnt_a - rd0 != 4) begin
      bad++;
      $display("FAIL basic_rd_count got=%0d want=4", rd_cnt_a - rd0);
    end
    total++;
    if (fd_rise_cyc != last_acc_cyc + 1) begin
      bad++;
      $display("FAIL basic_fd_latency got=%0d want=%0d", fd_rise_cyc, last_acc_cyc + 1);
    end
    total++;
    if (fd_a !== 1'b1) begin bad++; $display("FAIL basic_fd_hold got=%b want=1", fd_a); end
    fs_a = 1'b0;
    @(posedge clk); #1;
    total++;
    if (fd_a !== 1'b0) begin bad++; $display("FAIL basic_fd_drop got=%b want=0", fd_a); end
  endtask

  task automatic test_zero();
    logic [7:0] exp [$];
    int base, rd0;
    bit to;
    logic [8:0] got;
    exp = '{8'h55, 8'hAA, 8'h12, 8'h03, 8'h04, 8'h00, 8'h19};
    num = 8'h00;
    base = acc_a.size();
    rd0 = rd_cnt_a;
    run_frame(0, -1, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL zero_timeout got=no_fd want=fd"); end
    total++;
    if (acc_a.size() - base != exp.size()) begin
      bad++;
      $display("FAIL zero_len got=%0d want=%0d", acc_a.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < acc_a.size()) ? {last_a[base + i], acc_a[base + i]} : 'x;
      total++;
      if (got !== {1'(i == exp.size() - 1), exp[i]}) begin
        bad++;
        $display("FAIL zero_byte%0d got=%h want=%h", i, got, {1'(i == exp.size() - 1), exp[i]});
      end
    end
    total++;
    if (rd_cnt_a != rd0) begin bad++; $display("FAIL zero_rd_count got=%0d want=0", rd_cnt_a - rd0); end
    total++;
    if (fd_rise_cyc != last_acc_cyc + 1) begin
      bad++;
      $display("FAIL zero_fd_latency got=%0d want=%0d", fd_rise_cyc, last_acc_cyc + 1);
    end
    fs_a = 1'b0;
    @(posedge clk); #1;
    total++;
    if (fd_a !== 1'b0) begin bad++; $display("FAIL zero_fd_drop got=%b want=0", fd_a); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [$];
    int base;
    bit to;
    logic [8:0] got;
    exp = '{8'h55, 8'hAA, 8'h12, 8'h03, 8'h04, 8'h01, 8'h05, 8'h06, 8'h07, 8'h08, 8'h34};
    load_fifo(8'h05, 8'h06, 8'h07, 8'h08);
    num = 8'h01;
    txa.tx_ready = 1'b0;
    base = acc_a.size();
    run_frame(1, -1, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL bp_timeout got=no_fd want=fd"); end
    total++;
    if (acc_a.size() - base != exp.size()) begin
      bad++;
      $display("FAIL bp_len got=%0d want=%0d", acc_a.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < acc_a.size()) ? {last_a[base + i], acc_a[base + i]} : 'x;
      total++;
      if (got !== {1'(i == exp.size() - 1), exp[i]}) begin
        bad++;
        $display("FAIL bp_byte%0d got=%h want=%h", i, got, {1'(i == exp.size() - 1), exp[i]});
      end
    end
    total++;
    if (stab_a != 0) begin bad++; $display("FAIL bp_stability got=%0d_unstable_cycles want=0", stab_a); end
    fs_a = 1'b0;
    txa.tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fifo_stall();
    logic [7:0] exp [$];
    int base, rd0, sv0;
    bit to;
    logic [8:0] got;
    exp = '{8'h55, 8'hAA, 8'h12, 8'h03, 8'h04, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h24};
    load_fifo(8'h01, 8'h02, 8'h03, 8'h04);
    num = 8'h01;
    base = acc_a.size();
    rd0 = rd_cnt_a;
    sv0 = stall_viol;
    run_frame(0, 8, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL stall_timeout got=no_fd want=fd"); end
    total++;
    if (stall_viol != sv0) begin
      bad++;
      $display("FAIL stall_quiet got=%0d_active_cycles want=0", stall_viol - sv0);
    end
    total++;
    if (rd_empty_a != 0) begin bad++; $display("FAIL stall_rd_when_empty got=%0d want=0", rd_empty_a); end
    total++;
    if (rd_cnt_a - rd0 != 4) begin bad++; $display("FAIL stall_rd_count got=%0d want=4", rd_cnt_a - rd0); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < acc_a.size()) ? {last_a[base + i], acc_a[base + i]} : 'x;
      total++;
      if (got !== {1'(i == exp.size() - 1), exp[i]}) begin
        bad++;
        $display("FAIL stall_byte%0d got=%h want=%h", i, got, {1'(i == exp.size() - 1), exp[i]});
      end
    end
    fs_a = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [7:0] exp [$];
    int base, rd0;
    bit to;
    logic [8:0] got;
    exp = '{8'h55, 8'hAA, 8'h12, 8'h03, 8'h04, 8'h00, 8'h19};
    load_fifo(8'h01, 8'h02, 8'h03, 8'h04);
    num = 8'h01;
    base = acc_a.size();
    to = 1'b1;
    fs_a = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (acc_a.size() - base >= 8) begin to = 1'b0; break; end
    end
    total++;
    if (to) begin bad++; $display("FAIL abort_timeout got=%0d_bytes want=8", acc_a.size() - base); end
    rst_dev = 1'b1;
    #1;
    total++;
    if ({fd_a, rd_en_a, txa.tx_valid, txa.tx_last, txa.tx_data} !== 12'h000) begin
      bad++;
      $display("FAIL abort_outputs got=%h want=000", {fd_a, rd_en_a, txa.tx_valid, txa.tx_last, txa.tx_data});
    end
    num = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_dev = 1'b0;
    @(negedge clk); #1;
    total++;
    if (txa.tx_valid !== 1'b0) begin bad++; $display("FAIL abort_release_idle got=%b want=0", txa.tx_valid); end
    @(posedge clk); #1;
    total++;
    if ({txa.tx_valid, txa.tx_data} !== 9'h155) begin
      bad++;
      $display("FAIL abort_first_edge got=%h want=155", {txa.tx_valid, txa.tx_data});
    end
    base = acc_a.size();
    rd0 = rd_cnt_a;
    run_frame(0, -1, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL abort_fresh_timeout got=no_fd want=fd"); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < acc_a.size()) ? {last_a[base + i], acc_a[base + i]} : 'x;
      total++;
      if (got !== {1'(i == exp.size() - 1), exp[i]}) begin
        bad++;
        $display("FAIL abort_fresh_byte%0d got=%h want=%h", i, got, {1'(i == exp.size() - 1), exp[i]});
      end
    end
    total++;
    if (rd_cnt_a != rd0) begin bad++; $display("FAIL abort_fresh_rd got=%0d want=0", rd_cnt_a - rd0); end
    fs_a = 1'b0;
    num = 8'h01;
    @(posedge clk); #1;
  endtask

  task automatic test_big_frame();
    int sum;
    bit to;
    logic [7:0] exp_csum;
    sum = 32'h12 + 32'h03 + 32'h04 + 32'hFF;
    for (int i = 0; i < 8160; i++) sum += (i * 7 + 3) % 256;
    exp_csum = 8'(sum % 256);
    num = 8'hFF;
    fs_b = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 40000; c++) begin
      @(posedge clk); #1;
      if (fd_b) begin to = 1'b0; break; end
    end
    @(negedge clk); #1;
    total++;
    if (to) begin bad++; $display("FAIL big_timeout got=no_fd want=fd"); end
    total++;
    if (nb != 8167) begin bad++; $display("FAIL big_len got=%0d want=8167", nb); end
    total++;
    if (lastpos_b != 8167 || lastcnt_b != 1) begin
      bad++;
      $display("FAIL big_last got=pos%0d_cnt%0d want=pos8167_cnt1", lastpos_b, lastcnt_b);
    end
    total++;
    if (lastbyte_b !== exp_csum) begin bad++; $display("FAIL big_csum got=%h want=%h", lastbyte_b, exp_csum); end
    total++;
    if (rd_cnt_b != 8160) begin bad++; $display("FAIL big_rd_count got=%0d want=8160", rd_cnt_b); end
    fs_b = 1'b0;
    num = 8'h01;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_fifo_stall();
    test_reset_abort();
    test_big_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
